// File: rtl/conv_bcd_bin_2dig_pkg.sv
// Shared constants, FSM encoding and nibble helpers for the 2-digit BCD to binary converter.
//
// Contents:
//   BCD_W / ACC_W  : widths of the BCD shift register (2 nibbles) and binary accumulator (0..99)
//   ITER / CNT_W   : iteration count of the reverse double-dabble and its counter width
//   BCD_DIGIT_MAX  : largest legal BCD digit
//   BCD_ADJ_THRESH : a nibble at or above this after a right shift gets corrected
//   BCD_ADJ        : correction subtracted from such a nibble
//   state_t        : converter FSM states
package conv_bcd_bin_2dig_pkg;

    localparam int unsigned BCD_W = 8;
    localparam int unsigned ACC_W = 7;
    localparam int unsigned ITER  = 7;
    localparam int unsigned CNT_W = 3;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    // Undo the "add 3" of forward double-dabble once a digit has been halved.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        return (nib >= BCD_ADJ_THRESH) ? (nib - BCD_ADJ) : nib;
    endfunction

    function automatic logic digit_invalid(input logic [3:0] nib);
        return nib > BCD_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/conv_bcd_bin_2dig_if.sv
// Request/result bundle of the 2-digit BCD to binary converter.
//
// Signals:
//   start   : level request, honoured only while the converter is idle
//   digit1  : BCD tens digit
//   digit0  : BCD units digit
//   busy    : conversion in progress
//   done    : one-clock pulse, result valid
//   err     : last result invalid (bad digit or out of range)
//   bin_out : last valid converted value
// Modports: master drives the request, slave is the converter.
interface conv_bcd_bin_2dig_if #(
    parameter int unsigned N = 6
);

    logic         start;
    logic [3:0]   digit1;
    logic [3:0]   digit0;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] bin_out;

    modport master (
        output start,
        output digit1,
        output digit0,
        input  busy,
        input  done,
        input  err,
        input  bin_out
    );

    modport slave (
        input  start,
        input  digit1,
        input  digit0,
        output busy,
        output done,
        output err,
        output bin_out
    );

endinterface

// File: rtl/conv_bcd_bin_2dig_step.sv
// One combinational iteration of the reverse double-dabble.
//
// Ports:
//   bcd_in   : 8-bit BCD shift register (tens nibble in [7:4])
//   bin_in   : 7-bit binary accumulator
//   bcd_next : BCD register after shift-right and per-nibble correction
//   bin_next : accumulator after receiving the BCD LSB into its MSB
module bcd2bin_step
    import conv_bcd_bin_2dig_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [ACC_W-1:0] bin_in,
    output logic [BCD_W-1:0] bcd_next,
    output logic [ACC_W-1:0] bin_next
);

    logic [BCD_W-1:0] bcd_sh;

    // {bcd,bin} is treated as one 15-bit register shifted right by one.
    assign bcd_sh   = {1'b0, bcd_in[BCD_W-1:1]};
    assign bin_next = {bcd_in[0], bin_in[ACC_W-1:1]};
    assign bcd_next = {bcd_adjust(bcd_sh[7:4]), bcd_adjust(bcd_sh[3:0])};

endmodule

// File: rtl/conv_bcd_bin_2dig.sv
// Iterative 2-digit BCD to binary converter used to preload the RTC up/down counters.
//
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : synchronous active-high; returns to idle and clears all outputs
//   bus   : slave side of conv_bcd_bin_2dig_if (start/digits in, busy/done/err/bin_out out)
//
// Parameters:
//   N   : width of bin_out (2^N must exceed MAX)
//   MAX : largest legal decoded value
//
// Timing: start accepted at edge k, busy visible from edge k+1, done pulses from edge k+8.
// Outputs are registered from the FSM state, so they trail the state by one clock.
module conv_bcd_bin_2dig
    import conv_bcd_bin_2dig_pkg::*;
#(
    parameter int unsigned N   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic                clk,
    input  logic                reset,
    conv_bcd_bin_2dig_if.slave  bus
);

    localparam logic [ACC_W-1:0] MaxVal   = ACC_W'(MAX);
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITER - 1);

    state_t state_q, state_d;

    logic [BCD_W-1:0] bcd_q;
    logic [ACC_W-1:0] bin_q;
    logic [CNT_W-1:0] cnt_q;
    logic             digit_bad_q;

    logic [BCD_W-1:0] bcd_step;
    logic [ACC_W-1:0] bin_step;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [N-1:0]     bin_out_q, bin_out_d;

    logic accept;
    logic last_iter;
    logic result_bad;

    assign accept     = (state_q == StIdle) && bus.start;
    assign last_iter  = (cnt_q == LastIter);
    // Range check on the full accumulator, before truncation to N bits.
    assign result_bad = digit_bad_q || (bin_q > MaxVal);

    bcd2bin_step u_step (
        .bcd_in   (bcd_q),
        .bin_in   (bin_q),
        .bcd_next (bcd_step),
        .bin_next (bin_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StShift;
            StShift: if (last_iter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output next-values.
    always_comb begin
        busy_d    = (state_q != StIdle);
        done_d    = (state_q == StDone);
        err_d     = err_q;
        bin_out_d = bin_out_q;
        if (accept) begin
            err_d = 1'b0;
        end
        if (state_q == StDone) begin
            err_d = result_bad;
            if (!result_bad) begin
                bin_out_d = bin_q[N-1:0];
            end
        end
    end

    // Conversion datapath; iterations run even for bad digits so latency stays fixed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            digit_bad_q <= 1'b0;
        end else if (accept) begin
            bcd_q       <= {bus.digit1, bus.digit0};
            bin_q       <= '0;
            cnt_q       <= '0;
            digit_bad_q <= digit_invalid(bus.digit1) || digit_invalid(bus.digit0);
        end else if (state_q == StShift) begin
            bcd_q <= bcd_step;
            bin_q <= bin_step;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_out_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bin_out_q <= bin_out_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin_out = bin_out_q;

endmodule

// File: tb/tb_conv_bcd_bin_2dig.sv
// Self-checking bench for conv_bcd_bin_2dig: directed cases, ignored start, reset abort,
// back-to-back conversions and randomized digits against a decimal arithmetic model.
module tb_conv_bcd_bin_2dig;

    localparam int N   = 6;
    localparam int MAX = 59;

    logic clk;
    logic reset;

    conv_bcd_bin_2dig_if #(.N(N)) bus ();

    conv_bcd_bin_2dig #(
        .N   (N),
        .MAX (MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: last valid value and last error flag.
    int exp_bin = 0;
    bit exp_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Decimal model: value is 10*tens+units, rejected on a bad digit or when above MAX.
    task automatic model(input int d1, input int d0);
        int val;
        val     = d1 * 10 + d0;
        exp_err = (d1 > 9) || (d0 > 9) || (val > MAX);
        if (!exp_err) exp_bin = val;
    endtask

    // Issue one start pulse and follow the handshake. lat = edges from accept to done
    // (-1 if none), seq_bad counts busy/done sequencing violations, extra counts done pulses
    // after the first. inject_at > 0 pulses start with digits 4,4 sampled at that edge.
    task automatic run_conv(input logic [3:0] d1, input logic [3:0] d0, input int inject_at,
                            output int lat, output int seq_bad, output int extra);
        lat     = -1;
        seq_bad = 0;
        extra   = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.digit1 = d1;
        bus.digit0 = d0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) seq_bad++;
        for (int i = 1; i <= 20; i++) begin
            if (i == inject_at) begin
                bus.start  = 1'b1;
                bus.digit1 = 4'd4;
                bus.digit0 = 4'd4;
            end
            @(posedge clk);
            #1;
            if (i == inject_at) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = i;
                if (bus.busy !== 1'b1) seq_bad++;
                break;
            end
            if (bus.busy !== 1'b1) seq_bad++;
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seq_bad++;
            for (int j = 0; j < 12; j++) begin
                @(posedge clk);
                #1;
                if (bus.done === 1'b1) extra++;
            end
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.digit1 = 4'd0;
        bus.digit0 = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000)
            $display("FAIL reset_flags got busy/done/err=%b exp=000",
                     {bus.busy, bus.done, bus.err});
        else n_pass++;
        n_checks++;
        if (bus.bin_out !== 6'd0) $display("FAIL reset_bin got=%0d exp=0", bus.bin_out);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_conv(input string tag, input int d1, input int d0, input int inject);
        int lat, seq_bad, extra;
        run_conv(4'(d1), 4'(d0), inject, lat, seq_bad, extra);
        model(d1, d0);
        n_checks++;
        if (lat !== 8) $display("FAIL %s latency got=%0d exp=8", tag, lat);
        else n_pass++;
        n_checks++;
        if (seq_bad !== 0) $display("FAIL %s busy_done_seq got=%0d violations exp=0", tag, seq_bad);
        else n_pass++;
        n_checks++;
        if (extra !== 0) $display("FAIL %s extra_done got=%0d exp=0", tag, extra);
        else n_pass++;
        n_checks++;
        if (bus.err !== exp_err) $display("FAIL %s err got=%b exp=%b", tag, bus.err, exp_err);
        else n_pass++;
        n_checks++;
        if (bus.bin_out !== 6'(exp_bin))
            $display("FAIL %s bin_out got=%0d exp=%0d", tag, bus.bin_out, exp_bin);
        else n_pass++;
    endtask

    task automatic test_directed;
        int pairs [6][2] = '{'{5, 9}, '{0, 0}, '{1, 0}, '{3, 7}, '{7, 2}, '{0, 12}};
        for (int i = 0; i < 6; i++) begin
            check_conv($sformatf("directed_%0d%0d", pairs[i][0], pairs[i][1]),
                       pairs[i][0], pairs[i][1], 0);
        end
    endtask

    // Start during SHIFT and during DONE must not queue a second conversion.
    task automatic test_ignore_start;
        check_conv("ignore_in_shift", 5, 9, 3);
        check_conv("ignore_in_done", 1, 6, 8);
    endtask

    task automatic test_reset_abort;
        int stray;
        stray = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.digit1 = 4'd5;
        bus.digit0 = 4'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_bin = 0;
        exp_err = 0;
        n_checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000)
            $display("FAIL abort_flags got busy/done/err=%b exp=000",
                     {bus.busy, bus.done, bus.err});
        else n_pass++;
        n_checks++;
        if (bus.bin_out !== 6'd0) $display("FAIL abort_bin got=%0d exp=0", bus.bin_out);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) stray++;
        end
        n_checks++;
        if (stray !== 0) $display("FAIL abort_no_done got=%0d active cycles exp=0", stray);
        else n_pass++;
    endtask

    // start held high: 9-clock period, done at k+8/k+17/k+26, busy low at k+9/k+18/k+27.
    task automatic test_back_to_back;
        bit exp_done, exp_busy;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.digit1 = 4'd2;
        bus.digit0 = 4'd3;
        @(posedge clk);
        for (int i = 1; i <= 27; i++) begin
            @(posedge clk);
            #1;
            if (i == 27) bus.start = 1'b0;
            exp_done = (i % 9 == 8);
            exp_busy = (i % 9 != 0);
            n_checks++;
            if (bus.done !== exp_done)
                $display("FAIL b2b_done cycle %0d got=%b exp=%b", i, bus.done, exp_done);
            else n_pass++;
            n_checks++;
            if (bus.busy !== exp_busy)
                $display("FAIL b2b_busy cycle %0d got=%b exp=%b", i, bus.busy, exp_busy);
            else n_pass++;
            if (exp_done) begin
                model(2, 3);
                n_checks++;
                if (bus.bin_out !== 6'(exp_bin) || bus.err !== exp_err)
                    $display("FAIL b2b_result cycle %0d got=%0d/err=%b exp=%0d/err=%b",
                             i, bus.bin_out, bus.err, exp_bin, exp_err);
                else n_pass++;
            end
        end
        // Let the conversion accepted at k+27 drain.
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (bus.bin_out !== 6'(exp_bin) || bus.busy !== 1'b0)
            $display("FAIL b2b_drain got bin=%0d busy=%b exp bin=%0d busy=0",
                     bus.bin_out, bus.busy, exp_bin);
        else n_pass++;
    endtask

    task automatic test_random;
        int d1, d0;
        for (int i = 0; i < 40; i++) begin
            d1 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 15))
                                              : int'($urandom_range(0, 9));
            d0 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 15))
                                              : int'($urandom_range(0, 9));
            check_conv($sformatf("random_%0d_%0d_%0d", i, d1, d0), d1, d0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
